// File: rtl/dbus_responder.sv
// dbus_responder: single-outstanding data-bus target with programmable wait
// states in front of a byte-maskable word RAM.
// Optional build macro: DBUS_RESP_ERR_EN (flags misaligned / out-of-range
// requests as error responses instead of letting the address alias).
module dbus_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [DEPTH];

    logic              req_fire;
    logic              req_err;
    logic              enter_resp;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_we;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;

`ifdef DBUS_RESP_ERR_EN
    // Misaligned or beyond the RAM's byte range.
    assign req_err = (req_addr[1:0] != 2'b00) | (|req_addr[31:IDX_W+2]);
`else
    // Upper bits alias and the byte offset is ignored.
    logic unused_addr_bits;
    assign req_err          = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

    // No accept while reset is held, so a zero-wait write cannot slip into RAM.
    assign req_fire = req_valid & (state_q == IDLE) & ~rst;

    // With zero wait states the access happens on the accept edge itself, so
    // the live request is used; otherwise the latched copy is used.
    assign acc_idx   = (state_q == IDLE) ? req_addr[IDX_W+1:2] : idx_q;
    assign acc_we    = (state_q == IDLE) ? req_we              : we_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata           : wdata_q;
    assign acc_be    = (state_q == IDLE) ? req_be              : be_q;
    assign acc_err   = (state_q == IDLE) ? req_err             : err_q;

    assign enter_resp = (req_fire & (WAIT_CYCLES == 0)) |
                        ((state_q == WAIT) & (cnt_q == 4'd1) & ~rst);

    // Next-state, request latch and response data computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    idx_d   = req_addr[IDX_W+1:2];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    rdata_d   = 32'd0;
                    rsp_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rdata_d   = (acc_we | acc_err) ? 32'd0 : mem[acc_idx];
            rsp_err_d = acc_err;
        end
    end

    // Control and latched-request registers, all cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Byte-masked RAM write, committed on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed vector table, hand-written reset sequences and
// randomized traffic against a word-array reference model.
module tb_dbus_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];

    dbus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: a word array addressed by (addr / 4) mod DEPTH with a byte mask.
    task automatic model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic e);
        int unsigned word;
        logic [31:0] mask;
        word = (addr / 4) % DEPTH;
`ifdef DBUS_RESP_ERR_EN
        e = (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
        e = 1'b0;
`endif
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
        rd = 32'd0;
        if (!e) begin
            if (we) ref_mem[word] = (ref_mem[word] & ~mask) | (wdata & mask);
            else    rd = ref_mem[word];
        end
    endtask

    task automatic scramble();
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // One full transaction; returns the captured response and its latency.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input int hold,
                           output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            scramble();
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        e  = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            scramble();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_rdata", rsp_rdata, 32'd0);
        chk("post_err", 32'(rsp_err), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rd, mrd;
        logic        e, me;
        int          lat;
        bit          seen;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_addr = 32'd0; req_we = 1'b0; req_wdata = 32'd0; req_be = 4'd0;

        // Reset held with clock running
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", rsp_rdata, 32'd0);

        // Give every RAM word a known value
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            run_txn(32'(i * 4), 1'b1, v, 4'hF, 0, rd, e, lat);
            model(32'(i * 4), 1'b1, v, 4'hF, mrd, me);
        end

        vecs[0]  = '{32'h10,  1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
        vecs[1]  = '{32'h10,  1'b0, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{32'h10,  1'b1, 32'h0000AA00, 4'h2, 0, 32'h0, 1'b0};
        vecs[3]  = '{32'h10,  1'b0, 32'h0,        4'hF, 0, 32'hDEADAAEF, 1'b0};
        vecs[4]  = '{32'h10,  1'b1, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0};
        vecs[5]  = '{32'h10,  1'b0, 32'h0,        4'hF, 5, 32'hDEADAAEF, 1'b0};
        vecs[6]  = '{32'h20,  1'b1, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0};
        vecs[7]  = '{32'h20,  1'b0, 32'h0,        4'h0, 2, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{32'h0,   1'b1, 32'h11223344, 4'hF, 0, 32'h0, 1'b0};
`ifdef DBUS_RESP_ERR_EN
        vecs[9]  = '{32'h402, 1'b0, 32'h0,        4'hF, 0, 32'h0, 1'b1};
        vecs[10] = '{32'h402, 1'b1, 32'h55555555, 4'hF, 0, 32'h0, 1'b1};
`else
        vecs[9]  = '{32'h402, 1'b0, 32'h0,        4'hF, 0, 32'h11223344, 1'b0};
        vecs[10] = '{32'h0,   1'b0, 32'h0,        4'hF, 0, 32'h11223344, 1'b0};
`endif

        for (int v = 0; v < 11; v++) begin
            run_txn(vecs[v].addr, vecs[v].we, vecs[v].wdata, vecs[v].be, vecs[v].hold, rd, e, lat);
            model(vecs[v].addr, vecs[v].we, vecs[v].wdata, vecs[v].be, mrd, me);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(W + 1));
        end
`ifdef DBUS_RESP_ERR_EN
        run_txn(32'h0, 1'b0, 32'h0, 4'hF, 0, rd, e, lat);
        chk("err_write_suppressed", rd, 32'h11223344);
`endif

        // Reset in WAIT abandons a write to 0x20
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        run_txn(32'h20, 1'b0, 32'h0, 4'hF, 0, rd, e, lat);
        chk("midrst_ram_kept", rd, 32'hCAFEF00D);

        // Async reset between edges while a response is pending
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        chk("resp_pending", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'd0);
        chk("async_rdata", rsp_rdata, 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Randomized traffic including out-of-range and misaligned addresses
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a, wd;
            logic        w;
            logic [3:0]  b;
            int          hd;
            a  = $urandom_range(0, 2047);
            if ($urandom_range(0, 3) != 0) a = a & 32'h3FC;
            w  = 1'($urandom);
            wd = $urandom;
            b  = 4'($urandom);
            hd = $urandom_range(0, 3);
            run_txn(a, w, wd, b, hd, rd, e, lat);
            model(a, w, wd, b, mrd, me);
            chk($sformatf("rnd%0d_rdata", t), rd, mrd);
            chk($sformatf("rnd%0d_err", t), 32'(e), 32'(me));
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(W + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
